// File: rtl/bac_pkg.sv
// Shared types and constants for the Bulls and Cows guess-entry datapath.
// Latency: n/a (types only).
// Backpressure: n/a.
package bac_pkg;
    localparam int NUM_DIGITS_DEFAULT = 4;

    typedef logic [3:0] digit_t;

    localparam digit_t DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        OFFER   = 2'd2
    } entry_state_t;
endpackage

// File: rtl/press_detect.sv
// One-cycle press event from a level button; debounced when KEY_DEBOUNCE_EN is defined.
// Latency: event combinational from input (raw) or DEBOUNCE_CYCLES after a stable rise (debounced).
// Backpressure: none; a held level yields exactly one event.
module press_detect #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);
    logic level;
    logic prev;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("press_detect: DEBOUNCE_CYCLES must be >= 1");
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] stable_cnt;

    // The counter only runs while raw disagrees with the filtered level,
    // so any bounce back to the old level restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (raw != level) begin
            if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                level      <= raw;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end
`else
    assign level = raw;
`endif

    // History loads 1 on reset so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= level;
    end

    assign evt = level & ~prev;
endmodule

// File: rtl/guess_entry_buffer.sv
// Assembles a NUM_DIGITS-digit no-repeat guess from keypad presses and offers it (KEY_DEBOUNCE_EN adds debounce).
// Latency: 1 cycle press-to-update (DEBOUNCE_CYCLES+1 debounced); enter-in-FULL to guess_valid 1 cycle.
// Backpressure: guess held stable in OFFER until guess_ready; all buttons ignored meanwhile.
module guess_entry_buffer
    import bac_pkg::*;
#(
    parameter int NUM_DIGITS      = NUM_DIGITS_DEFAULT,
    parameter int CNT_W           = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    key_any,
    input  logic [3:0]              digit_in,
    input  logic                    btn_del,
    input  logic                    btn_enter,
    input  logic                    guess_ready,
    output logic [4*NUM_DIGITS-1:0] guess,
    output logic                    guess_valid,
    output logic [CNT_W-1:0]        digit_count,
    output logic                    entry_full,
    output logic                    dup_err
);
    localparam int GW = 4 * NUM_DIGITS;

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || (1 << CNT_W) <= NUM_DIGITS) begin : g_bad_cfg
        $error("guess_entry_buffer: illegal NUM_DIGITS/CNT_W combination");
    end

    logic         key_evt;
    logic         del_evt;
    logic         enter_evt;
    logic         reject;
    entry_state_t state;

    press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk(CLK), .rst(rst), .raw(key_any),   .evt(key_evt)
    );
    press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_del (
        .clk(CLK), .rst(rst), .raw(btn_del),   .evt(del_evt)
    );
    press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(CLK), .rst(rst), .raw(btn_enter), .evt(enter_evt)
    );

    // Only the low digit_count nibbles hold entered digits; the rest are zero padding.
    always_comb begin
        reject = (digit_in > DIGIT_MAX);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (CNT_W'(i) < digit_count && guess[4*i +: 4] == digit_in) reject = 1'b1;
        end
    end

    assign entry_full = (digit_count == CNT_W'(NUM_DIGITS));

    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= COLLECT;
            guess       <= '0;
            guess_valid <= 1'b0;
            digit_count <= '0;
            dup_err     <= 1'b0;
        end else begin
            dup_err <= 1'b0;
            case (state)
                COLLECT: begin
                    // Enter is ignored here but still outranks and drops del/key.
                    if (enter_evt) begin
                        state <= COLLECT;
                    end else if (del_evt) begin
                        if (digit_count != '0) begin
                            guess       <= guess >> 4;
                            digit_count <= digit_count - 1'b1;
                        end
                    end else if (key_evt) begin
                        if (reject) begin
                            dup_err <= 1'b1;
                        end else begin
                            guess       <= {guess[GW-5:0], digit_in};
                            digit_count <= digit_count + 1'b1;
                            if (digit_count + 1'b1 == CNT_W'(NUM_DIGITS)) state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (enter_evt) begin
                        state       <= OFFER;
                        guess_valid <= 1'b1;
                    end else if (del_evt) begin
                        guess       <= guess >> 4;
                        digit_count <= digit_count - 1'b1;
                        state       <= COLLECT;
                    end
                end
                OFFER: begin
                    if (guess_ready) begin
                        guess_valid <= 1'b0;
                        guess       <= '0;
                        digit_count <= '0;
                        state       <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_guess_entry_buffer.sv
// Directed bench for guess_entry_buffer with hand-computed expectations.
// Latency: n/a.
// Backpressure: guess_ready driven directly by the sequence.
module tb_guess_entry_buffer;
    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        key_any = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic        btn_del = 1'b0;
    logic        btn_enter = 1'b0;
    logic        guess_ready = 1'b0;
    logic [15:0] guess;
    logic        guess_valid;
    logic [2:0]  digit_count;
    logic        entry_full;
    logic        dup_err;

    int vectors = 0;
    int miscompares = 0;
    int dup_cnt = 0;
    int dup_run = 0;
    int dup_max_run = 0;

`ifdef KEY_DEBOUNCE_EN
    localparam int HOLD = 20;
`else
    localparam int HOLD = 3;
`endif

    guess_entry_buffer #(.NUM_DIGITS(4), .CNT_W(3), .DEBOUNCE_CYCLES(16)) dut (
        .CLK(CLK), .rst(rst), .key_any(key_any), .digit_in(digit_in),
        .btn_del(btn_del), .btn_enter(btn_enter), .guess_ready(guess_ready),
        .guess(guess), .guess_valid(guess_valid), .digit_count(digit_count),
        .entry_full(entry_full), .dup_err(dup_err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (dup_err) begin
            dup_cnt++;
            dup_run++;
            if (dup_run > dup_max_run) dup_max_run = dup_run;
        end else begin
            dup_run = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_key(input logic [3:0] d);
        digit_in = d;
        key_any  = 1'b1;
        step(HOLD);
        key_any  = 1'b0;
        step(HOLD);
    endtask

    task automatic press_del();
        btn_del = 1'b1;
        step(HOLD);
        btn_del = 1'b0;
        step(HOLD);
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        step(HOLD);
        btn_enter = 1'b0;
        step(HOLD);
    endtask

    initial begin
        step(2);
        chk("rst_guess", 32'(guess), 32'h0);
        chk("rst_valid", 32'(guess_valid), 32'h0);
        chk("rst_count", 32'(digit_count), 32'h0);
        chk("rst_dup", 32'(dup_err), 32'h0);
        chk("rst_full", 32'(entry_full), 32'h0);
        rst = 1'b0;
        step(1);

        // Fill 1,2,3,4
`ifndef KEY_DEBOUNCE_EN
        digit_in = 4'd1;
        key_any  = 1'b1;
        step(1);
        chk("lat1_count", 32'(digit_count), 32'd1);
        chk("lat1_guess", 32'(guess), 32'h0001);
        step(HOLD - 1);
        key_any = 1'b0;
        step(HOLD);
`else
        press_key(4'd1);
        chk("fill_count1", 32'(digit_count), 32'd1);
`endif
        press_key(4'd2);
        chk("fill_count2", 32'(digit_count), 32'd2);
        press_key(4'd3);
        chk("fill_count3", 32'(digit_count), 32'd3);
        chk("fill_full3", 32'(entry_full), 32'd0);
        press_key(4'd4);
        chk("fill_count4", 32'(digit_count), 32'd4);
        chk("fill_guess", 32'(guess), 32'h1234);
        chk("fill_full4", 32'(entry_full), 32'd1);
        press_key(4'd5);
        chk("full_ignore_key", 32'(guess), 32'h1234);
        chk("fill_no_dup", 32'(dup_cnt), 32'd0);

        // Clear, then duplicate and out-of-range rejection
        press_del();
        chk("full_del_guess", 32'(guess), 32'h0123);
        press_del();
        press_del();
        press_del();
        chk("clear_count", 32'(digit_count), 32'd0);
        press_key(4'd5);
        press_key(4'd7);
        press_key(4'd5);
        chk("dup_pulse", 32'(dup_cnt), 32'd1);
        chk("dup_guess", 32'(guess), 32'h0057);
        chk("dup_count", 32'(digit_count), 32'd2);
        press_key(4'hA);
        chk("range_pulse", 32'(dup_cnt), 32'd2);
        chk("range_guess", 32'(guess), 32'h0057);
        chk("range_count", 32'(digit_count), 32'd2);
        chk("dup_one_cycle", 32'(dup_max_run), 32'd1);

        // Delete and saturation at zero
        press_del();
        press_del();
        press_key(4'd9);
        press_key(4'd8);
        press_key(4'd7);
        press_del();
        chk("del_guess", 32'(guess), 32'h0098);
        chk("del_count", 32'(digit_count), 32'd2);
        press_del();
        press_del();
        press_del();
        chk("del_sat_count", 32'(digit_count), 32'd0);
        chk("del_sat_guess", 32'(guess), 32'h0);
        chk("del_sat_no_dup", 32'(dup_cnt), 32'd2);

        // Offer with backpressure
        press_key(4'd4);
        press_key(4'd0);
        press_key(4'd2);
        press_key(4'd6);
        press_enter();
        for (int i = 0; i < 5; i++) begin
            chk("offer_valid", 32'(guess_valid), 32'd1);
            chk("offer_guess", 32'(guess), 32'h4026);
            step(1);
        end
        guess_ready = 1'b1;
        step(1);
        guess_ready = 1'b0;
        chk("accept_valid", 32'(guess_valid), 32'd0);
        chk("accept_count", 32'(digit_count), 32'd0);
        chk("accept_guess", 32'(guess), 32'h0);

        // Long hold registers once; del beats key in the same cycle
        digit_in = 4'd3;
        key_any  = 1'b1;
        step(20);
        key_any  = 1'b0;
        step(HOLD);
        chk("hold_once", 32'(digit_count), 32'd1);
        press_key(4'd5);
        chk("hold_then_5", 32'(guess), 32'h0035);
        digit_in = 4'd7;
        key_any  = 1'b1;
        btn_del  = 1'b1;
        step(HOLD);
        key_any  = 1'b0;
        btn_del  = 1'b0;
        step(HOLD);
        chk("prio_count", 32'(digit_count), 32'd1);
        chk("prio_guess", 32'(guess), 32'h0003);
        press_del();

        // Reset mid-offer
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd4);
        press_enter();
        chk("pre_rst_valid", 32'(guess_valid), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_offer_valid", 32'(guess_valid), 32'd0);
        chk("rst_offer_count", 32'(digit_count), 32'd0);
        chk("rst_offer_guess", 32'(guess), 32'h0);
        step(2);

`ifdef KEY_DEBOUNCE_EN
        // Glitch shorter than the window is filtered; a stable press lands 17 cycles after rise
        digit_in = 4'd8;
        key_any  = 1'b1;
        step(5);
        key_any  = 1'b0;
        step(25);
        chk("glitch_count", 32'(digit_count), 32'd0);
        key_any = 1'b1;
        step(16);
        chk("deb_lat_before", 32'(digit_count), 32'd0);
        step(1);
        chk("deb_lat_count", 32'(digit_count), 32'd1);
        chk("deb_lat_guess", 32'(guess), 32'h0008);
        step(3);
        key_any = 1'b0;
        step(20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
